rr_select_arbiter: RTL and testbench
====================================

// Module: rr_select_arbiter
// PURPOSE
//  Round-robin arbiter that generates the 2-bit select for the 4:1 data mux downstream.
//  Four sources raise requests. The arbiter grants one source, drives its index onto select,
//  and holds the grant until the consumer signals done. It then rotates priority so no
//  source starves.
// PARAMETERS
//  MAX_HOLD  8  max cycles a grant may be held when RR_HOLD_TIMEOUT_EN is defined (>=2)
//  CNT_W     4  hold-counter width; must satisfy 2**CNT_W >= MAX_HOLD
// PORTS
//  clk      in   1  rising-edge clock
//  rst_n    in   1  reset, asynchronous assert, active-low
//  req      in   4  request per source; bit i = mux input i (a=0,b=1,c=2,d=3)
//  done     in   1  consumer finished with current grant; sampled only in GRANT
//  select   out  2  mux select, registered; index of granted source
//  grant    out  4  one-hot grant, registered; 0 when no grant
//  valid    out  1  registered; 1 while select/grant are meaningful
//  timeout  out  1  one-cycle pulse on forced release; constant 0 when feature is compiled out
// BEHAVIOUR
//  - Reset (rst_n=0, async): select=2'b00, grant=4'b0000, valid=0, timeout=0.
//    Internal state: state=IDLE, ptr=0, hold_cnt=0. All outputs registered.
//  - FSM states: IDLE, GRANT.
//  - IDLE:
//    - req==0: stay in IDLE.
//    - else: winner = first set bit of req, searching ptr, ptr+1, ... mod 4.
//    - Next edge: select=winner, grant=1<<winner, valid=1, state=GRANT.
//    - Latency is 1 cycle from req sampled to valid=1.
//  - GRANT:
//    - select and grant held stable.
//    - Release condition: done=1, OR req[select]=0 (requester withdrew).
//    - On release edge: valid=0, grant=0, select holds its last value,
//      ptr=select+1 mod 4 (3 wraps to 0), state=IDLE.
//    - A new grant therefore needs at least one IDLE cycle: valid has a 1-cycle gap
//      between back-to-back grants.
//  - done while IDLE is ignored. Requests from other sources during GRANT do not preempt.
//  - Simultaneous done and req change: release takes priority. The new req set is
//    evaluated in the following IDLE cycle.
//  - Single requester: re-granted after every 1-cycle gap. Rotation never skips it.
//  - grant is always one-hot or zero. select==index of the grant bit whenever valid=1.
//  - Reset mid-GRANT clears everything immediately, with no waiting for clk.
//    The first grant after reset searches from index 0.
// CONFIGURATION
//  Macro RR_HOLD_TIMEOUT_EN:
//  - Defined:
//    - hold_cnt clears on entry to GRANT and increments each GRANT cycle.
//    - If hold_cnt reaches MAX_HOLD-1 without a release condition, a forced release
//      occurs on the next edge, identical to a done release (ptr advances), and
//      timeout=1 for exactly that one cycle.
//    - done on the same cycle as the limit counts as a normal release, timeout=0.
//  - Undefined: hold counter is absent, timeout is tied 0, and a grant is held
//    indefinitely until done or the requester withdraws.
// TESTING
//  1. Reset: rst_n=0 mid-sim with req=4'b1111 -> select=00, grant=0000, valid=0
//     immediately, with no clk edge needed.
//  2. Rotation: req=4'b1111 held, done pulsed 1 cycle after each grant -> select
//     sequence 00,01,10,11,00. Between grants valid drops for exactly 1 cycle.
//  3. Wrap: ptr=3 after granting 2, req=4'b0101 -> next grant select=00
//     (index 3 empty, 0 wins), grant=0001.
//  4. Withdraw: grant on 1 (req=0010), req->0000 without done -> next edge valid=0.
//     Then req=0010 again -> re-granted select=01 after 1 IDLE cycle.
//  5. Stray done: done=1 with req=0000 in IDLE -> no state change, outputs stay
//     valid=0, grant=0000.
//  6. Timeout (RR_HOLD_TIMEOUT_EN, MAX_HOLD=8): req=0100 held, done=0 ->
//     forced release 8 cycles after valid rose, timeout=1 for 1 cycle.
//     Without the macro the grant stays valid for 50+ cycles.

Source files
------------

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the 2-bit select of a downstream 4:1 mux; grant held until done/withdraw.
// Optional forced release after MAX_HOLD cycles when RR_HOLD_TIMEOUT_EN is defined.
module rr_select_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] select,
  output logic [3:0] grant,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] win_idx;
  logic [1:0] scan_idx;
  logic       found;
  logic       rel_now;

  if (MAX_HOLD < 2 || (2 ** CNT_W) < MAX_HOLD) begin : g_bad_params
    $error("rr_select_arbiter: MAX_HOLD must be >= 2 and fit in CNT_W bits");
  end

  // Search starts at ptr and wraps, so the last granted source has lowest priority.
  always_comb begin
    win_idx  = ptr;
    scan_idx = ptr;
    found    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (!found && req[scan_idx]) begin
        win_idx = scan_idx;
        found   = 1'b1;
      end
    end
  end

  assign rel_now = done | ~req[select];

`ifdef RR_HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_lim;

  assign hold_lim = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      select   <= 2'd0;
      grant    <= 4'b0000;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            select   <= win_idx;
            grant    <= 4'b0001 << win_idx;
            valid    <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A real release condition on the limit cycle wins; timeout only flags a forced one.
          if (rel_now || hold_lim) begin
            grant   <= 4'b0000;
            valid   <= 1'b0;
            ptr     <= select + 2'd1;
            timeout <= ~rel_now;
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      select  <= 2'd0;
      grant   <= 4'b0000;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            select <= win_idx;
            grant  <= 4'b0001 << win_idx;
            valid  <= 1'b1;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (rel_now) begin
            grant <= 4'b0000;
            valid <= 1'b0;
            ptr   <= select + 2'd1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed bench for rr_select_arbiter: rotation, wrap, withdraw, stray done, no-preempt, hold timeout, async reset.
module tb_rr_select_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] select;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_select_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .select  (select),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic v, input logic [1:0] s,
                         input logic [3:0] g, input logic t);
    chk({tag, ".valid"},   32'(valid),   32'(v));
    chk({tag, ".select"},  32'(select),  32'(s));
    chk({tag, ".grant"},   32'(grant),   32'(g));
    chk({tag, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    repeat (2) step();
    exp_out("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst_n = 1'b1;
    step();
    exp_out("idle_after_reset", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Rotation with all four requesting; done pulsed right after each grant.
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      exp_out($sformatf("rot%0d_grant", i), 1'b1, 2'(i % 4), 4'b0001 << (i % 4), 1'b0);
      done = 1'b1;
      step();
      done = 1'b0;
      exp_out($sformatf("rot%0d_gap", i), 1'b0, 2'(i % 4), 4'b0000, 1'b0);
      if (i == 4) req = 4'b0100;
    end

    // Grant 2 so the pointer lands on 3, then index 3 empty -> 0 wins.
    step();
    exp_out("wrap_g2", 1'b1, 2'd2, 4'b0100, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0101;
    exp_out("wrap_rel", 1'b0, 2'd2, 4'b0000, 1'b0);
    step();
    exp_out("wrap_g0", 1'b1, 2'd0, 4'b0001, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = 4'b0010;
    exp_out("wrap_rel0", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Withdraw without done, then re-request.
    step();
    exp_out("wd_grant", 1'b1, 2'd1, 4'b0010, 1'b0);
    req = 4'b0000;
    step();
    exp_out("wd_drop", 1'b0, 2'd1, 4'b0000, 1'b0);
    req = 4'b0010;
    step();
    exp_out("wd_regrant", 1'b1, 2'd1, 4'b0010, 1'b0);
    req = 4'b0000;
    step();
    exp_out("wd_drop2", 1'b0, 2'd1, 4'b0000, 1'b0);

    // Stray done in IDLE is ignored.
    done = 1'b1;
    step();
    exp_out("stray1", 1'b0, 2'd1, 4'b0000, 1'b0);
    step();
    exp_out("stray2", 1'b0, 2'd1, 4'b0000, 1'b0);
    done = 1'b0;

    // Pointer is 2: lone request on 0 wins; extra request on 3 does not preempt.
    req = 4'b0001;
    step();
    exp_out("np_grant", 1'b1, 2'd0, 4'b0001, 1'b0);
    req = 4'b1001;
    step();
    exp_out("np_hold", 1'b1, 2'd0, 4'b0001, 1'b0);
    // done together with a req change: release first, new set evaluated next cycle.
    done = 1'b1;
    req  = 4'b1000;
    step();
    done = 1'b0;
    exp_out("sim_rel", 1'b0, 2'd0, 4'b0000, 1'b0);
    step();
    exp_out("sim_g3", 1'b1, 2'd3, 4'b1000, 1'b0);
    req = 4'b0000;
    step();
    exp_out("sim_drop", 1'b0, 2'd3, 4'b0000, 1'b0);

    // Long hold on source 2 with no done.
    req = 4'b0100;
    step();
    exp_out("hold_grant", 1'b1, 2'd2, 4'b0100, 1'b0);
`ifdef RR_HOLD_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      step();
      exp_out($sformatf("hold%0d", k), 1'b1, 2'd2, 4'b0100, 1'b0);
    end
    step();
    exp_out("to_pulse", 1'b0, 2'd2, 4'b0000, 1'b1);
    req = 4'b0000;
    step();
    exp_out("to_end", 1'b0, 2'd2, 4'b0000, 1'b0);
`else
    for (int k = 1; k <= 60; k++) begin
      step();
      chk($sformatf("hold%0d.valid", k), 32'(valid), 32'd1);
      chk($sformatf("hold%0d.timeout", k), 32'(timeout), 32'd0);
    end
    exp_out("hold_end", 1'b1, 2'd2, 4'b0100, 1'b0);
`endif

    // Async reset in the middle of a grant, away from any clock edge.
    req = 4'b1111;
    step();
    chk("pre_reset.valid", 32'(valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_out("async_reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    exp_out("post_reset_g0", 1'b1, 2'd0, 4'b0001, 1'b0);
    done = 1'b1;
    step();
    done = 1'b0;
    exp_out("post_reset_rel", 1'b0, 2'd0, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
